hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the pipeline hazard unit. Generates forwarding selects
//   and IF/ID/EX stall and flush controls over N forwarding stages.
//  Adds a per-register busy scoreboard for long-latency writers (loads, mul/div)
//   that complete out of band: RAW/WAW stalls, an outstanding-op limit, and a
//   saturating stall-cycle counter. Sits beside the ID stage of the core.
// PARAMETERS
//  NREGS       32  architectural registers; index width RAW = $clog2(NREGS)
//  FWD_STAGES  3   forwarding sources; index 0 is the youngest (EX) stage
//  MAX_PEND    4   max outstanding long-latency writes (>=1)
//  CNT_W       32  stall counter width
// PORTS
//  clk            in   1               clock
//  rst            in   1               reset: synchronous, active-high
//  id_valid       in   1               valid instruction in ID
//  id_rs1/id_rs2  in   RAW             source register indices
//  id_rs1_used    in   1               rs1 is read (same for id_rs2_used)
//  id_rd          in   RAW             destination register
//  id_reg_wr      in   1               instruction writes rd
//  id_long_lat    in   1               rd is written via the completion port
//  stg_rd         in   FWD_STAGES*RAW  rd of each forwarding stage
//  stg_wr         in   FWD_STAGES      stage holds a valid write to rd
//  stg_ready      in   FWD_STAGES      stage result is available for forwarding
//  cmp_valid      in   1               long-latency completion (regfile written this edge)
//  cmp_rd         in   RAW             completing register
//  muldiv_busy    in   1               EX-resident iterative unit busy
//  branch_mispredict in 1              resolved in EX; kills ID and EX
//  fwd_rs1/fwd_rs2 out $clog2(FWD_STAGES+1)  0 = regfile; s+1 = stage s
//  stall_if/stall_id/stall_ex  out 1   hold stage registers
//  flush_id/flush_ex out 1             bubble into stage
//  sb_busy        out  NREGS           scoreboard state
//  pend_cnt       out  $clog2(MAX_PEND+1)  outstanding long-latency ops
//  stall_cycles   out  CNT_W           cycles with stall_id asserted
// BEHAVIOUR
//  Reset (sync): sb_busy=0, pend_cnt=0, stall_cycles=0. During rst: all stall_*=0,
//   flush_id=flush_ex=1, fwd_*=0.
//  Forwarding (combinational): for rsN with rsN_used && rsN!=0, take the lowest s with
//   stg_wr[s] && stg_rd[s]==rsN. fwd_rsN=s+1 if stg_ready[s]; otherwise hazard_N=1.
//   No match: fwd_rsN=0.
//  raw_sb : id_valid && a used, nonzero rsN has sb_busy[rsN]=1.
//  waw_sb : id_valid && id_reg_wr && id_rd!=0 && sb_busy[id_rd].
//  full   : id_valid && id_long_lat && pend_cnt==MAX_PEND.
//  Scoreboard reads use registered state only. A completion does not bypass the
//   same cycle; the stall releases the next cycle and the value is read from the regfile.
//  Priority (highest first):
//   1 branch_mispredict: flush_id=flush_ex=1; stall_if=stall_id=0.
//     stall_ex=muldiv_busy. No issue.
//   2 muldiv_busy: stall_if=stall_id=stall_ex=1.
//   3 any of hazard_1, hazard_2, raw_sb, waw_sb, full: stall_if=stall_id=1, flush_ex=1.
//   4 otherwise: none asserted. The ID instruction issues if id_valid.
//  Issue set: an issuing instruction with id_long_lat && id_reg_wr && id_rd!=0
//   sets sb_busy[id_rd] and increments pend_cnt.
//  Completion: cmp_valid && cmp_rd!=0 clears sb_busy[cmp_rd] and decrements pend_cnt.
//   Completion of a non-busy register is ignored (no decrement).
//  Same-cycle issue and completion: net pend_cnt change is 0.
//   Same-register set/clear cannot occur, because waw_sb blocks it.
//  Flush does not touch the scoreboard: in-flight long-latency ops are older than the branch.
//  stall_cycles += 1 when stall_id=1; saturates at all-ones.
// TESTING
//  1 EX writes x5 ready, ID reads rs1=x5 -> fwd_rs1=1, no stall.
//    Same with stg_ready[0]=0 -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle.
//  2 x5 in stage 0 and stage 2 -> fwd_rs1=1 (youngest wins). rs1=x0 -> fwd_rs1=0.
//  3 Issue long-lat load to x7, then a reader of x7 -> stall until cycle after cmp_valid(x7).
//    sb_busy[7] 1->0, pend_cnt 1->0.
//  4 Issue 4 long-lat ops (MAX_PEND=4), 5th stalls.
//    Completion + new issue same cycle -> pend_cnt stays 4, stall releases next cycle.
//  5 Mispredict while raw_sb stall -> flush_id=flush_ex=1, stalls 0, no sb_busy change.
//    muldiv_busy=1 -> stall_ex=1.
//  6 Assert rst with sb_busy!=0 -> next edge all state 0.
//    Force 2^CNT_W-1 stall cycles (CNT_W=4) -> stall_cycles holds 15.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: ID-stage request, forwarding stages and completions
// in, forwarding selects, stall/flush controls and scoreboard state out.
interface hazard_scoreboard_if #(
  parameter int NREGS      = 32,
  parameter int FWD_STAGES = 3,
  parameter int MAX_PEND   = 4,
  parameter int CNT_W      = 32
);
  localparam int RAW = $clog2(NREGS);
  localparam int FW  = $clog2(FWD_STAGES + 1);
  localparam int PW  = $clog2(MAX_PEND + 1);

  logic                      id_valid;
  logic [RAW-1:0]            id_rs1;
  logic [RAW-1:0]            id_rs2;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [RAW-1:0]            id_rd;
  logic                      id_reg_wr;
  logic                      id_long_lat;
  logic [FWD_STAGES*RAW-1:0] stg_rd;
  logic [FWD_STAGES-1:0]     stg_wr;
  logic [FWD_STAGES-1:0]     stg_ready;
  logic                      cmp_valid;
  logic [RAW-1:0]            cmp_rd;
  logic                      muldiv_busy;
  logic                      branch_mispredict;

  logic [FW-1:0]             fwd_rs1;
  logic [FW-1:0]             fwd_rs2;
  logic                      stall_if;
  logic                      stall_id;
  logic                      stall_ex;
  logic                      flush_id;
  logic                      flush_ex;
  logic [NREGS-1:0]          sb_busy;
  logic [PW-1:0]             pend_cnt;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_reg_wr, id_long_lat,
    output stg_rd, stg_wr, stg_ready,
    output cmp_valid, cmp_rd, muldiv_busy, branch_mispredict,
    input  fwd_rs1, fwd_rs2,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex,
    input  sb_busy, pend_cnt, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_wr, id_long_lat,
    input  stg_rd, stg_wr, stg_ready,
    input  cmp_valid, cmp_rd, muldiv_busy, branch_mispredict,
    output fwd_rs1, fwd_rs2,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex,
    output sb_busy, pend_cnt, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding select, stall/flush control and long-latency busy scoreboard
// for the ID stage.
module hazard_scoreboard #(
  parameter int NREGS      = 32,
  parameter int FWD_STAGES = 3,
  parameter int MAX_PEND   = 4,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int RAW = $clog2(NREGS);
  localparam int FW  = $clog2(FWD_STAGES + 1);
  localparam int PW  = $clog2(MAX_PEND + 1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [FW-1:0] f1, f2;
  logic          h1, h2;
  logic          rs1_chk, rs2_chk;
  logic          raw_sb, waw_sb, full, hz;
  logic          s_if, s_id, s_ex, fl_id, fl_ex;
  logic          issue, set_v, clr_v;

  assign rs1_chk = bus.id_rs1_used && (bus.id_rs1 != '0);
  assign rs2_chk = bus.id_rs2_used && (bus.id_rs2 != '0);

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    f1 = '0;
    h1 = 1'b0;
    f2 = '0;
    h2 = 1'b0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      if (rs1_chk && bus.stg_wr[s] &&
          bus.stg_rd[s*RAW +: RAW] == bus.id_rs1) begin
        f1 = bus.stg_ready[s] ? FW'(s + 1) : '0;
        h1 = !bus.stg_ready[s];
      end
      if (rs2_chk && bus.stg_wr[s] &&
          bus.stg_rd[s*RAW +: RAW] == bus.id_rs2) begin
        f2 = bus.stg_ready[s] ? FW'(s + 1) : '0;
        h2 = !bus.stg_ready[s];
      end
    end
  end

  assign raw_sb = bus.id_valid &&
                  ((rs1_chk && busy_q[bus.id_rs1]) ||
                   (rs2_chk && busy_q[bus.id_rs2]));
  assign waw_sb = bus.id_valid && bus.id_reg_wr &&
                  (bus.id_rd != '0) && busy_q[bus.id_rd];
  assign full   = bus.id_valid && bus.id_long_lat &&
                  (pend_q == PW'(MAX_PEND));
  assign hz     = h1 || h2 || raw_sb || waw_sb || full;

  always_comb begin
    s_if  = 1'b0;
    s_id  = 1'b0;
    s_ex  = 1'b0;
    fl_id = 1'b0;
    fl_ex = 1'b0;
    issue = 1'b0;
    priority case (1'b1)
      rst: begin
        fl_id = 1'b1;
        fl_ex = 1'b1;
      end
      bus.branch_mispredict: begin
        fl_id = 1'b1;
        fl_ex = 1'b1;
        s_ex  = bus.muldiv_busy;
      end
      bus.muldiv_busy: begin
        s_if = 1'b1;
        s_id = 1'b1;
        s_ex = 1'b1;
      end
      hz: begin
        s_if  = 1'b1;
        s_id  = 1'b1;
        fl_ex = 1'b1;
      end
      default: issue = bus.id_valid;
    endcase
  end

  // Completions never bypass: the scoreboard only sees registered state.
  always_comb begin
    set_v  = issue && bus.id_long_lat && bus.id_reg_wr &&
             (bus.id_rd != '0);
    clr_v  = bus.cmp_valid && (bus.cmp_rd != '0) &&
             busy_q[bus.cmp_rd];
    busy_d = busy_q;
    if (clr_v) busy_d[bus.cmp_rd] = 1'b0;
    if (set_v) busy_d[bus.id_rd] = 1'b1;
    pend_d = pend_q + PW'(set_v) - PW'(clr_v);
    cnt_d  = cnt_q;
    if (s_id && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.fwd_rs1      = rst ? '0 : f1;
  assign bus.fwd_rs2      = rst ? '0 : f2;
  assign bus.stall_if     = s_if;
  assign bus.stall_id     = s_id;
  assign bus.stall_ex     = s_ex;
  assign bus.flush_id     = fl_id;
  assign bus.flush_ex     = fl_ex;
  assign bus.sb_busy      = busy_q;
  assign bus.pend_cnt     = pend_q;
  assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: forwarding vector table, scoreboard sequences,
// then random traffic against a behavioural model.
module tb_hazard_scoreboard;
  localparam int NR = 32;
  localparam int FS = 3;
  localparam int MP = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(
    .NREGS(NR), .FWD_STAGES(FS), .MAX_PEND(MP), .CNT_W(CW)
  ) bus ();

  hazard_scoreboard #(
    .NREGS(NR), .FWD_STAGES(FS), .MAX_PEND(MP), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit mbusy[NR];
  int mpend;
  int mstall;

  typedef struct {
    logic [1:0] f1, f2;
    bit sif, sid, sex, fid, fex, issue;
  } ctl_t;

  typedef struct {
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [14:0] srd;
    logic [2:0]  swr;
    logic [2:0]  srdy;
    logic [1:0]  e1;
    logic [1:0]  e2;
    logic        est;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void fwd_of(input logic [4:0] r, input logic used,
                                 output logic [1:0] f, output bit h);
    f = 2'd0;
    h = 1'b0;
    if (!used || r == 5'd0) return;
    for (int s = 0; s < FS; s++) begin
      if (bus.stg_wr[s] && bus.stg_rd[s*5 +: 5] == r) begin
        if (bus.stg_ready[s]) f = 2'(s + 1);
        else h = 1'b1;
        return;
      end
    end
  endfunction

  function automatic ctl_t model();
    ctl_t c;
    bit h1, h2, raw, waw, full;
    c = '{default: 0};
    if (rst) begin
      c.fid = 1;
      c.fex = 1;
      return c;
    end
    fwd_of(bus.id_rs1, bus.id_rs1_used, c.f1, h1);
    fwd_of(bus.id_rs2, bus.id_rs2_used, c.f2, h2);
    raw = bus.id_valid &&
          ((bus.id_rs1_used && bus.id_rs1 != 0 && mbusy[bus.id_rs1]) ||
           (bus.id_rs2_used && bus.id_rs2 != 0 && mbusy[bus.id_rs2]));
    waw = bus.id_valid && bus.id_reg_wr && bus.id_rd != 0 &&
          mbusy[bus.id_rd];
    full = bus.id_valid && bus.id_long_lat && mpend == MP;
    if (bus.branch_mispredict) begin
      c.fid = 1;
      c.fex = 1;
      c.sex = bus.muldiv_busy;
    end else if (bus.muldiv_busy) begin
      c.sif = 1;
      c.sid = 1;
      c.sex = 1;
    end else if (h1 || h2 || raw || waw || full) begin
      c.sif = 1;
      c.sid = 1;
      c.fex = 1;
    end else begin
      c.issue = bus.id_valid;
    end
    return c;
  endfunction

  function automatic logic [NR-1:0] mvec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic cycle();
    ctl_t c;
    logic [4:0] crd, rd;
    bit cv, setv;
    c = model();
    #1;
    chk("fwd_rs1", bus.fwd_rs1, c.f1);
    chk("fwd_rs2", bus.fwd_rs2, c.f2);
    chk("stall_if", bus.stall_if, c.sif);
    chk("stall_id", bus.stall_id, c.sid);
    chk("stall_ex", bus.stall_ex, c.sex);
    chk("flush_id", bus.flush_id, c.fid);
    chk("flush_ex", bus.flush_ex, c.fex);
    cv   = bus.cmp_valid;
    crd  = bus.cmp_rd;
    rd   = bus.id_rd;
    setv = c.issue && bus.id_long_lat && bus.id_reg_wr && rd != 0;
    @(posedge clk);
    if (rst) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      mpend  = 0;
      mstall = 0;
    end else begin
      if (cv && crd != 0 && mbusy[crd]) begin
        mbusy[crd] = 0;
        mpend--;
      end
      if (setv) begin
        mbusy[rd] = 1;
        mpend++;
      end
      if (c.sid && mstall < (2**CW - 1)) mstall++;
    end
    #1;
    chk("sb_busy", bus.sb_busy, mvec());
    chk("pend_cnt", bus.pend_cnt, mpend);
    chk("stall_cycles", bus.stall_cycles, mstall);
  endtask

  task automatic idle();
    bus.id_valid = 0;
    bus.id_rs1 = 0;
    bus.id_rs2 = 0;
    bus.id_rs1_used = 0;
    bus.id_rs2_used = 0;
    bus.id_rd = 0;
    bus.id_reg_wr = 0;
    bus.id_long_lat = 0;
    bus.stg_rd = 0;
    bus.stg_wr = 0;
    bus.stg_ready = 0;
    bus.cmp_valid = 0;
    bus.cmp_rd = 0;
    bus.muldiv_busy = 0;
    bus.branch_mispredict = 0;
  endtask

  task automatic issue_ll(input int r);
    bus.id_valid = 1;
    bus.id_long_lat = 1;
    bus.id_reg_wr = 1;
    bus.id_rd = 5'(r);
    bus.id_rs1_used = 0;
    bus.id_rs2_used = 0;
  endtask

  task automatic reader(input int r);
    bus.id_valid = 1;
    bus.id_long_lat = 0;
    bus.id_reg_wr = 0;
    bus.id_rs1 = 5'(r);
    bus.id_rs1_used = 1;
    bus.id_rs2_used = 0;
  endtask

  initial begin
    foreach (mbusy[i]) mbusy[i] = 0;
    mpend  = 0;
    mstall = 0;
    vt[0] = '{5'd5, 1'b1, 5'd0, 1'b0, {5'd0, 5'd0, 5'd5},
              3'b001, 3'b001, 2'd1, 2'd0, 1'b0};
    vt[1] = '{5'd5, 1'b1, 5'd0, 1'b0, {5'd0, 5'd0, 5'd5},
              3'b001, 3'b000, 2'd0, 2'd0, 1'b1};
    vt[2] = '{5'd5, 1'b1, 5'd0, 1'b0, {5'd5, 5'd0, 5'd5},
              3'b101, 3'b101, 2'd1, 2'd0, 1'b0};
    vt[3] = '{5'd0, 1'b1, 5'd0, 1'b0, {5'd0, 5'd0, 5'd0},
              3'b001, 3'b001, 2'd0, 2'd0, 1'b0};
    vt[4] = '{5'd5, 1'b0, 5'd6, 1'b1, {5'd0, 5'd6, 5'd5},
              3'b011, 3'b011, 2'd0, 2'd2, 1'b0};
    vt[5] = '{5'd3, 1'b1, 5'd3, 1'b1, {5'd3, 5'd0, 5'd0},
              3'b100, 3'b100, 2'd3, 2'd3, 1'b0};
    vt[6] = '{5'd5, 1'b1, 5'd0, 1'b0, {5'd0, 5'd5, 5'd5},
              3'b011, 3'b010, 2'd0, 2'd0, 1'b1};
    vt[7] = '{5'd5, 1'b1, 5'd0, 1'b0, {5'd0, 5'd0, 5'd5},
              3'b000, 3'b001, 2'd0, 2'd0, 1'b0};
    vt[8] = '{5'd4, 1'b1, 5'd4, 1'b1, {5'd4, 5'd4, 5'd0},
              3'b110, 3'b100, 2'd0, 2'd0, 1'b1};

    idle();
    rst = 1;
    cycle();
    cycle();
    chk("rst_busy", bus.sb_busy, 0);
    chk("rst_pend", bus.pend_cnt, 0);
    chk("rst_cnt", bus.stall_cycles, 0);
    rst = 0;

    foreach (vt[i]) begin
      idle();
      bus.id_valid = 1;
      bus.id_rs1 = vt[i].rs1;
      bus.id_rs1_used = vt[i].u1;
      bus.id_rs2 = vt[i].rs2;
      bus.id_rs2_used = vt[i].u2;
      bus.stg_rd = vt[i].srd;
      bus.stg_wr = vt[i].swr;
      bus.stg_ready = vt[i].srdy;
      #1;
      chk($sformatf("vec%0d_fwd1", i), bus.fwd_rs1, vt[i].e1);
      chk($sformatf("vec%0d_fwd2", i), bus.fwd_rs2, vt[i].e2);
      chk($sformatf("vec%0d_stall", i),
          {bus.stall_if, bus.stall_id, bus.flush_ex, bus.stall_ex, bus.flush_id},
          {vt[i].est, vt[i].est, vt[i].est, 2'b00});
      cycle();
    end

    // Load-use on a not-ready EX result lasts one cycle once it advances
    idle();
    reader(5);
    bus.stg_rd = 15'd5;
    bus.stg_wr = 3'b001;
    bus.stg_ready = 3'b000;
    #1 chk("lu_stall", bus.stall_id, 1);
    cycle();
    bus.stg_rd = {5'd0, 5'd5, 5'd0};
    bus.stg_wr = 3'b010;
    bus.stg_ready = 3'b010;
    #1 chk("lu_release", bus.stall_id, 0);
    chk("lu_fwd", bus.fwd_rs1, 2);
    cycle();

    idle();
    issue_ll(7);
    cycle();
    chk("ld_busy7", bus.sb_busy[7], 1);
    chk("ld_pend1", bus.pend_cnt, 1);
    reader(7);
    for (int k = 0; k < 3; k++) begin
      #1 chk("raw_stall", bus.stall_id, 1);
      cycle();
    end
    bus.cmp_valid = 1;
    bus.cmp_rd = 7;
    #1 chk("raw_nobypass", bus.stall_id, 1);
    cycle();
    chk("cmp_busy7", bus.sb_busy[7], 0);
    chk("cmp_pend0", bus.pend_cnt, 0);
    bus.cmp_valid = 0;
    #1 chk("raw_release", bus.stall_id, 0);
    cycle();

    idle();
    for (int r = 8; r < 12; r++) begin
      issue_ll(r);
      cycle();
    end
    chk("pend_full", bus.pend_cnt, 4);
    issue_ll(12);
    #1 chk("full_stall", bus.stall_id, 1);
    cycle();
    bus.cmp_valid = 1;
    bus.cmp_rd = 8;
    #1 chk("full_stall_cmp", bus.stall_id, 1);
    cycle();
    chk("pend_after_cmp", bus.pend_cnt, 3);
    bus.cmp_valid = 0;
    #1 chk("full_release", bus.stall_id, 0);
    cycle();
    chk("pend_refill", bus.pend_cnt, 4);
    idle();
    bus.cmp_valid = 1;
    bus.cmp_rd = 10;
    cycle();
    issue_ll(13);
    bus.cmp_rd = 11;
    cycle();
    chk("pend_net0", bus.pend_cnt, 3);

    idle();
    reader(9);
    bus.branch_mispredict = 1;
    #1 chk("mp_flush", {bus.flush_id, bus.flush_ex}, 2'b11);
    chk("mp_stall", {bus.stall_if, bus.stall_id, bus.stall_ex}, 3'b000);
    cycle();
    chk("mp_busy", bus.sb_busy, (32'd1 << 9) | (32'd1 << 12) | (32'd1 << 13));
    bus.muldiv_busy = 1;
    #1 chk("mp_md_ex", bus.stall_ex, 1);
    chk("mp_md_id", bus.stall_id, 0);
    cycle();
    bus.branch_mispredict = 0;
    #1 chk("md_stall", {bus.stall_if, bus.stall_id, bus.stall_ex}, 3'b111);
    cycle();

    idle();
    #1 chk("pre_rst_busy", bus.sb_busy != 0, 1);
    rst = 1;
    cycle();
    chk("rst2_busy", bus.sb_busy, 0);
    chk("rst2_pend", bus.pend_cnt, 0);
    chk("rst2_cnt", bus.stall_cycles, 0);
    rst = 0;
    reader(5);
    bus.stg_rd = 15'd5;
    bus.stg_wr = 3'b001;
    for (int k = 0; k < 20; k++) cycle();
    chk("sat_cnt", bus.stall_cycles, 15);

    idle();
    rst = 1;
    cycle();
    rst = 0;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.id_valid = $urandom_range(0, 3) != 0;
      bus.id_rs1 = 5'($urandom_range(0, 7));
      bus.id_rs2 = 5'($urandom_range(0, 7));
      bus.id_rs1_used = 1'($urandom);
      bus.id_rs2_used = 1'($urandom);
      bus.id_rd = 5'($urandom_range(0, 7));
      bus.id_reg_wr = $urandom_range(0, 3) != 0;
      bus.id_long_lat = $urandom_range(0, 2) == 0;
      bus.stg_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7))};
      bus.stg_wr = 3'($urandom);
      bus.stg_ready = 3'($urandom);
      bus.cmp_valid = $urandom_range(0, 2) == 0;
      bus.cmp_rd = 5'($urandom_range(0, 7));
      bus.muldiv_busy = $urandom_range(0, 7) == 0;
      bus.branch_mispredict = $urandom_range(0, 9) == 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
